// File: rtl/fpu_sp_issue.sv
// Single-precision FPU issue block: latches one host operation, starts the FPU,
// waits for completion or timeout, and holds the response until the host acks it.
module fpu_sp_issue #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_timeout,
  input  logic        resp_ack,
  output logic [31:0] fpu_din1,
  output logic [31:0] fpu_din2,
  output logic        fpu_dval,
  input  logic [31:0] fpu_result,
  input  logic        fpu_rdy,
  output logic        stray_rdy
);

  localparam logic [7:0]  CntLast = 8'(TIMEOUT_CYC - 1);
  localparam logic [31:0] QNaN    = 32'hFFC00000;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] din1_q, din1_d;
  logic [31:0] din2_q, din2_d;
  logic [31:0] data_q, data_d;
  logic        timeout_q, timeout_d;
  logic        stray_q, stray_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      din1_q    <= 32'd0;
      din2_q    <= 32'd0;
      data_q    <= 32'd0;
      timeout_q <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      din1_q    <= din1_d;
      din2_q    <= din2_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
      stray_q   <= stray_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    din1_d    = din1_q;
    din2_d    = din2_q;
    data_d    = data_q;
    timeout_d = timeout_q;
    // Completion outside WAIT belongs to no live operation (e.g. late after a timeout).
    stray_d   = stray_q | (fpu_rdy && (state_q != StWait));

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          din1_d  = req_a;
          din2_d  = req_b;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        // A real completion wins over a timeout landing in the same cycle.
        if (fpu_rdy) begin
          data_d    = fpu_result;
          timeout_d = 1'b0;
          state_d   = StResp;
        end else if (cnt_q == CntLast) begin
          data_d    = QNaN;
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        if (resp_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready    = (state_q == StIdle);
  assign fpu_dval     = (state_q == StIssue);
  assign resp_valid   = (state_q == StResp);
  assign resp_data    = data_q;
  assign resp_timeout = timeout_q;
  assign fpu_din1     = din1_q;
  assign fpu_din2     = din2_q;
  assign stray_rdy    = stray_q;

endmodule
